p2f_pattern_checker: RTL
========================

# p2f_pattern_checker

Consumes the 128-bit read side of the pipe-in (host-to-FPGA) width-converting FIFO in the `sys_clk` domain. Checks each word against the host's incrementing 32-bit test pattern, and reports word count, error count, first-error index and transfer duration in `sys_clk` cycles. It is the downstream stage of the BTPipe-in speed test and replaces the free-running discard reader, so host throughput runs can also be verified for data integrity.

## Interface
Parameters:
- `DATA_W`, 128: FIFO read width; must be a multiple of 32.
- `CNT_W`, 32: width of the word, error and cycle counters.

Ports:
- `sys_clk`, in, 1: single clock for all logic.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse. Begins a run; ignored unless IDLE or DONE.
- `xfer_words`, in, CNT_W: number of DATA_W words expected. Sampled on `start`.
- `seed`, in, 32: value of the first 32-bit host word. Sampled on `start`.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO read strobe (standard read mode, not FWFT).
- `fifo_dout`, in, DATA_W: FIFO read data.
- `fifo_valid`, in, 1: `fifo_dout` is valid this cycle.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse on the RUN→DONE transition.
- `pass`, out, 1: in DONE, high iff `err_cnt == 0`.
- `word_cnt`, out, CNT_W: DATA_W words received this run.
- `err_cnt`, out, CNT_W: mismatching words; saturates at all-ones.
- `first_err_idx`, out, CNT_W: index of the first mismatching word. All-ones if none.
- `cycle_cnt`, out, CNT_W: cycles from the first valid word to the last valid word, inclusive.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when `word_cnt` reaches `xfer_words`.
  - DONE→RUN on `start`.
  - `start` with `xfer_words == 0` goes IDLE/DONE→DONE directly. The `done` pulse fires next cycle and `pass=1`.
- On `start`, the block clears all counters, sets `first_err_idx` to all-ones, and loads `issued=0` and `expect=seed`.
- Read issue: `fifo_rd_en = RUN && !fifo_empty && issued < xfer_words`. `issued` increments on each strobe. The block never over-reads the FIFO.
- Lane order: the first-written 32-bit word occupies the MSBs. For an expected base `e`, the expected word is `{e, e+1, e+2, e+3}`, with `e` in `[DATA_W-1 -: 32]`. All 32-bit additions wrap modulo 2^32.
- On `fifo_valid` in RUN:
  - `word_cnt` increments.
  - `expect += DATA_W/32`. It always advances; there is no resync on error.
  - On any lane mismatch, `err_cnt` increments (saturating). If `first_err_idx` is still all-ones, it loads the current word index (`word_cnt` before increment).
- `cycle_cnt`:
  - Starts at 1 on the first valid word of a run.
  - Increments every cycle while RUN and at least one word has been received.
  - Freezes on the cycle the last word arrives.
  - Saturates at all-ones.
- `fifo_valid` outside RUN is ignored and not counted.
- `start` during RUN is ignored.
- `rstn` low at any time, including mid-run, forces IDLE asynchronously. All outputs return to reset values. In-flight FIFO data is the FIFO's responsibility: the FIFO shares the same reset.

## Timing
- Reset values: `fifo_rd_en=0`, `busy=0`, `done=0`, `pass=0`, `word_cnt=0`, `err_cnt=0`, `cycle_cnt=0`, `first_err_idx` all-ones.
- `start` at cycle t: `busy=1` at t+1. The earliest `fifo_rd_en` is at t+1.
- `fifo_rd_en` at cycle t gives `fifo_valid` at t+1. Compare and count updates are visible at t+2.
- Last word valid at cycle t: `word_cnt`, `err_cnt` and `cycle_cnt` final at t+1. `done` is pulsed at t+1, with `busy=0` and `pass` valid.
- Sustained throughput is one DATA_W word per cycle while the FIFO is non-empty. `rd_en` deasserts in the same cycle that `fifo_empty` is seen (combinational gate).
- Outputs hold in DONE until the next `start` or reset.

## Structure
- Package `p2f_chk_pkg`:
  - state enum `chk_state_t` {IDLE, RUN, DONE}.
  - `LANES = DATA_W/32`.
  - `IDX_NONE` (all-ones constant).
- Lane comparison is a generate loop in the top module.
- The one natural sub-module is `sat_counter` (CNT_W, clear, inc, saturate), reused for `err_cnt` and `cycle_cnt`.

## Test plan
- `seed=0`, `xfer_words=4`, FIFO preloaded with the correct pattern (words {0,1,2,3} … {12,13,14,15}), `fifo_empty` low throughout → exactly 4 `rd_en` strobes; `done` at the last valid +1; `word_cnt=4`, `err_cnt=0`, `pass=1`, `cycle_cnt=4`, `first_err_idx=FFFFFFFF`.
- Same run, but lane 2 of word 1 set to 0xDEAD → `err_cnt=1`, `first_err_idx=1`, `pass=0`. Words 2–3 still match, confirming no resync.
- `seed=FFFFFFFE`, `xfer_words=2` → expected words {FFFFFFFE, FFFFFFFF, 0, 1} and {2, 3, 4, 5} pass, confirming 32-bit wrap.
- `xfer_words=8` with `fifo_empty` toggling every 3 cycles → `rd_en` is never high while empty; `word_cnt=8`; `cycle_cnt` equals the first-to-last valid span.
- `xfer_words=0` → `done` one cycle after `start`, `pass=1`, no `rd_en`. A second `start` during a later RUN is ignored.
- `rstn` pulsed low mid-run after 3 of 10 words → outputs return to reset values immediately. A fresh `start` then completes a 10-word run normally.

Source files
------------

// File: rtl/p2f_chk_pkg.sv
// Shared types and constants for the pipe-in pattern checker.
package p2f_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } chk_state_t;

    localparam int unsigned LANE_W     = 32;
    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned LANES      = DATA_W_DEF / LANE_W;
    localparam logic [CNT_W_DEF-1:0] IDX_NONE = '1;

endpackage

// File: rtl/p2f_pattern_checker_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         sys_clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/p2f_pattern_checker.sv
// Reads the pipe-in FIFO and checks each word against the host's incrementing
// 32-bit pattern, reporting counts, first error index and transfer duration.
module p2f_pattern_checker
    import p2f_chk_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  xfer_words,
    input  logic [31:0]       seed,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned N_LANES = DATA_W / LANE_W;

    chk_state_t          state, state_nxt;
    logic [CNT_W-1:0]    xfer_q;
    logic [CNT_W-1:0]    issued;
    logic [LANE_W-1:0]   expect_q;
    logic [N_LANES-1:0]  lane_err;
    logic                accept;
    logic                word_in;
    logic                last_word;
    logic                word_err;
    logic                cyc_inc;

    assign accept     = start && (state != RUN);
    assign word_in    = (state == RUN) && fifo_valid;
    assign last_word  = word_in && ((word_cnt + CNT_W'(1)) == xfer_q);
    assign word_err   = word_in && (|lane_err);
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued < xfer_q);
    assign busy       = (state == RUN);
    assign pass       = (state == DONE) && (err_cnt == '0);
    assign cyc_inc    = (state == RUN) && (fifo_valid || (word_cnt != '0));

    // First host word sits in the MSB lane; later lanes carry base+1, base+2, ...
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign lane_err[i] = fifo_dout[DATA_W-1-LANE_W*i -: LANE_W] != (expect_q + LANE_W'(i));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (xfer_words == '0) ? DONE : RUN;
            RUN:        if (last_word) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            xfer_q        <= '0;
            issued        <= '0;
            expect_q      <= '0;
            word_cnt      <= '0;
            first_err_idx <= '1;
            done          <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (accept && (xfer_words == '0)) || last_word;
            if (accept) begin
                xfer_q        <= xfer_words;
                issued        <= '0;
                expect_q      <= seed;
                word_cnt      <= '0;
                first_err_idx <= '1;
            end else begin
                if (fifo_rd_en) issued <= issued + CNT_W'(1);
                if (word_in) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    expect_q <= expect_q + LANE_W'(N_LANES);
                end
                if (word_err && (first_err_idx == '1)) first_err_idx <= word_cnt;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .clr     (accept),
        .inc     (word_err),
        .cnt     (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .clr     (accept),
        .inc     (cyc_inc),
        .cnt     (cycle_cnt)
    );

endmodule
